// File: rtl/uart_tx_pkg.sv
// Shared UART TX/RX definitions: framer state encoding and parity-type constants.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_ser_parity.sv
// Parity bit generator shared by the UART TX framer and RX checker; purely combinational.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    assign parity_o = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx_frame_ser.sv
// UART TX framer/serialiser: start, data (LSB/MSB first), optional parity, 1-2 stop bits.
// Start bit appears the cycle after accept; requests while Busy are dropped, not queued.
module uart_tx_frame_ser
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_2,
    input  logic                  MSB_FIRST,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  msb_q, msb_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  par_bit;
    logic [IDX_W-1:0]      nxt_idx;
    logic [IDX_W-1:0]      sel;
    logic                  data_bit;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .parity_o  (par_bit)
    );

    // Outputs are registered, so the bit for the *next* cycle is selected here.
    assign nxt_idx  = (state_q == DATA && idx_q != LAST_IDX) ? idx_q + IDX_W'(1) : '0;
    assign sel      = msb_q ? (LAST_IDX - nxt_idx) : nxt_idx;
    assign data_bit = data_q[sel];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        msb_d    = msb_q;
        par_d    = par_q;
        tx_d     = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Data_Valid) begin
                    state_d  = START;
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    stop2_d  = STOP_2;
                    msb_d    = MSB_FIRST;
                    par_d    = par_bit;
                    idx_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                idx_d   = '0;
                tx_d    = data_bit;
            end
            DATA: begin
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    stop_d = 1'b0;
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                        done_d  = !stop2_q;
                    end
                end else begin
                    idx_d = nxt_idx;
                    tx_d  = data_bit;
                end
            end
            PARITY: begin
                state_d = STOP;
                stop_d  = 1'b0;
                done_d  = !stop2_q;
            end
            STOP: begin
                if (stop2_q && !stop_q) begin
                    stop_d = 1'b1;
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                stop_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            msb_q    <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            msb_q    <= msb_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ser.sv
// Directed bench for uart_tx_frame_ser at DATA_WIDTH 8 and 5.
module tb_uart_tx_frame_ser;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic [4:0] P_DATA5;
    logic       Data_Valid, Data_Valid5;
    logic       PAR_EN, PAR_TYP, STOP_2, MSB_FIRST;
    logic       tx8, busy8, done8;
    logic       tx5, busy5, done5;

    int errs   = 0;
    int checks = 0;

    logic tx_s[32], busy_s[32], done_s[32];
    logic tx5_s[32], busy5_s[32], done5_s[32];

    always #5 CLK = ~CLK;

    uart_tx_frame_ser #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_2(STOP_2), .MSB_FIRST(MSB_FIRST),
        .TX_OUT(tx8), .Busy(busy8), .frame_done(done8)
    );

    uart_tx_frame_ser #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA5), .Data_Valid(Data_Valid5),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_2(STOP_2), .MSB_FIRST(MSB_FIRST),
        .TX_OUT(tx5), .Busy(busy5), .frame_done(done5)
    );

    // Leaves the bench at the falling edge of the start-bit cycle.
    task automatic accept(input logic w5, input logic [7:0] d, input logic pen,
                          input logic ptyp, input logic s2, input logic msb);
        @(negedge CLK);
        PAR_EN = pen; PAR_TYP = ptyp; STOP_2 = s2; MSB_FIRST = msb;
        if (w5) begin
            P_DATA5 = d[4:0]; Data_Valid5 = 1'b1;
        end else begin
            P_DATA = d; Data_Valid = 1'b1;
        end
        @(negedge CLK);
        Data_Valid = 1'b0; Data_Valid5 = 1'b0;
    endtask

    task automatic capture(input int n, input int poke_at, input logic [7:0] poke_d,
                           input logic poke_v);
        for (int i = 0; i < n; i++) begin
            tx_s[i] = tx8;  busy_s[i] = busy8;  done_s[i] = done8;
            tx5_s[i] = tx5; busy5_s[i] = busy5; done5_s[i] = done5;
            if (i == poke_at) begin
                P_DATA = poke_d; MSB_FIRST = ~MSB_FIRST; PAR_TYP = ~PAR_TYP;
                STOP_2 = ~STOP_2; PAR_EN = ~PAR_EN; Data_Valid = poke_v;
            end else begin
                Data_Valid = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({tx8, busy8, done8} !== 3'b100) begin
            errs++; $display("FAIL reset_w8: got %b expected 100", {tx8, busy8, done8});
        end
        checks++;
        if ({tx5, busy5, done5} !== 3'b100) begin
            errs++; $display("FAIL reset_w5: got %b expected 100", {tx5, busy5, done5});
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_basic;
        string et = "010100101111", eb = "111111111100", ed = "000000000100";
        logic [2:0] exp;
        accept(0, 8'hA5, 0, 0, 0, 0);
        capture(12, -1, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            exp = {et[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                errs++;
                $display("FAIL basic_a5 cycle %0d: got %b expected %b", i,
                         {tx_s[i], busy_s[i], done_s[i]}, exp);
            end
        end
    endtask

    task automatic test_parity;
        string et_e = "0101001010111", et_o = "0101001011111";
        string eb = "1111111111100", ed = "0000000000100";
        logic [2:0] exp;
        for (int k = 0; k < 2; k++) begin
            accept(0, 8'hA5, 1, k[0], 0, 0);
            capture(13, -1, 8'h00, 0);
            for (int i = 0; i < 13; i++) begin
                exp = {(k == 0 ? et_e[i] : et_o[i]) == "1", eb[i] == "1", ed[i] == "1"};
                checks++;
                if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                    errs++;
                    $display("FAIL parity_typ%0d cycle %0d: got %b expected %b", k, i,
                             {tx_s[i], busy_s[i], done_s[i]}, exp);
                end
            end
        end
    endtask

    task automatic test_odd_two_stop;
        string et = "01110000001111", eb = "11111111111100", ed = "00000000000100";
        logic [2:0] exp;
        accept(0, 8'h07, 1, 1, 1, 0);
        capture(14, -1, 8'h00, 0);
        for (int i = 0; i < 14; i++) begin
            exp = {et[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                errs++;
                $display("FAIL odd_stop2 cycle %0d: got %b expected %b", i,
                         {tx_s[i], busy_s[i], done_s[i]}, exp);
            end
        end
    endtask

    task automatic test_msb_first;
        string et = "010000000111", eb = "111111111100", ed = "000000000100";
        logic [2:0] exp;
        accept(0, 8'h80, 0, 0, 0, 1);
        capture(12, 3, 8'h01, 0);
        for (int i = 0; i < 12; i++) begin
            exp = {et[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                errs++;
                $display("FAIL msb_first cycle %0d: got %b expected %b", i,
                         {tx_s[i], busy_s[i], done_s[i]}, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        string et1 = "010100101111", et2 = "000111100111";
        string eb = "111111111100", ed = "000000000100";
        logic [2:0] exp;
        accept(0, 8'hA5, 0, 0, 0, 0);
        capture(12, 4, 8'h3C, 1);
        for (int i = 0; i < 12; i++) begin
            exp = {et1[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                errs++;
                $display("FAIL busy_ignore cycle %0d: got %b expected %b", i,
                         {tx_s[i], busy_s[i], done_s[i]}, exp);
            end
        end
        accept(0, 8'h3C, 0, 0, 0, 0);
        capture(12, -1, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            exp = {et2[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                errs++;
                $display("FAIL next_accept cycle %0d: got %b expected %b", i,
                         {tx_s[i], busy_s[i], done_s[i]}, exp);
            end
        end
    endtask

    task automatic test_mid_reset;
        string et = "010101010111", eb = "111111111100", ed = "000000000100";
        logic [2:0] exp;
        accept(0, 8'hA5, 0, 0, 0, 0);
        capture(4, -1, 8'h00, 0);
        checks++;
        if ({tx8, busy8, done8} !== 3'b010) begin
            errs++; $display("FAIL pre_abort_bit3: got %b expected 010", {tx8, busy8, done8});
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({tx8, busy8, done8} !== 3'b100) begin
            errs++; $display("FAIL abort_reset: got %b expected 100", {tx8, busy8, done8});
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        accept(0, 8'h55, 0, 0, 0, 0);
        capture(12, -1, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            exp = {et[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx_s[i], busy_s[i], done_s[i]} !== exp) begin
                errs++;
                $display("FAIL post_reset_55 cycle %0d: got %b expected %b", i,
                         {tx_s[i], busy_s[i], done_s[i]}, exp);
            end
        end
    endtask

    task automatic test_width5;
        string et = "010100111", eb = "111111100", ed = "000000100";
        logic [2:0] exp;
        accept(1, 8'hA5, 0, 0, 0, 0);
        capture(9, -1, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            exp = {et[i] == "1", eb[i] == "1", ed[i] == "1"};
            checks++;
            if ({tx5_s[i], busy5_s[i], done5_s[i]} !== exp) begin
                errs++;
                $display("FAIL w5_basic cycle %0d: got %b expected %b", i,
                         {tx5_s[i], busy5_s[i], done5_s[i]}, exp);
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        P_DATA = '0; P_DATA5 = '0;
        Data_Valid = 1'b0; Data_Valid5 = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP_2 = 1'b0; MSB_FIRST = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_odd_two_stop;
        test_msb_first;
        test_back_to_back;
        test_mid_reset;
        test_width5;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
